int_gen: RTL and testbench

- Programmable external interrupt source for the CPU's `interrupt` input; the responder end of the CPU's interrupt-acknowledge interface (`m_int_addr` / `m_int_byteen`).
- Raises a level interrupt after a programmed cycle count and holds it until the CPU acknowledges with a store to the acknowledge address.
- Supports one-shot or periodic mode and counts missed periods.
- Configured from the system/bench side through a small register port; sits beside the CPU top, outside the bridge.

---
 rtl/int_gen.sv | 141 ++++++++++++++
 tb/tb_int_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/int_gen.sv
// Programmable external interrupt source: counts a programmed period, raises a level
// interrupt and holds it until the CPU stores to the acknowledge address.
module int_gen #(
    parameter logic [31:0] ACK_ADDR = 32'h0000_7F20,
    parameter int          CNT_W    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_int_addr,
    input  logic [3:0]  m_int_byteen,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        interrupt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        ASSERTED = 2'd2
    } state_t;

    state_t           r_state, w_state_nx;
    logic             r_en, w_en_nx;
    logic             r_mode, w_mode_nx;
    logic [CNT_W-1:0] r_period, w_period_nx;
    logic [CNT_W-1:0] r_count, w_count_nx;
    logic [7:0]       r_miss, w_miss_nx;
    logic             r_int, w_int_nx;

    logic             w_ack;
    logic             w_expire;
    logic [CNT_W-1:0] w_p;

    assign w_ack    = (m_int_addr[31:2] == ACK_ADDR[31:2]) && (|m_int_byteen);
    assign w_expire = (r_count == CNT_W'(1));
    assign w_p      = (r_period == '0) ? CNT_W'(1) : r_period;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_en     <= 1'b0;
            r_mode   <= 1'b0;
            r_period <= '0;
            r_count  <= '0;
            r_miss   <= 8'd0;
            r_int    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_en     <= w_en_nx;
            r_mode   <= w_mode_nx;
            r_period <= w_period_nx;
            r_count  <= w_count_nx;
            r_miss   <= w_miss_nx;
            r_int    <= w_int_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_en_nx     = r_en;
        w_mode_nx   = r_mode;
        w_period_nx = r_period;
        w_count_nx  = r_count;
        w_miss_nx   = r_miss;
        w_int_nx    = r_int;

        case (r_state)
            IDLE: ;
            COUNTING: begin
                if (w_expire) begin
                    w_state_nx = ASSERTED;
                    w_int_nx   = 1'b1;
                    w_count_nx = w_p;
                end else begin
                    w_count_nx = r_count - CNT_W'(1);
                end
            end
            ASSERTED: begin
                if (r_mode) begin
                    // An ack landing on an expiry edge is consumed by the new period.
                    if (w_expire) begin
                        w_count_nx = w_p;
                        if (!w_ack && r_miss != 8'hFF)
                            w_miss_nx = r_miss + 8'd1;
                    end else begin
                        w_count_nx = r_count - CNT_W'(1);
                        if (w_ack) begin
                            w_int_nx   = 1'b0;
                            w_state_nx = COUNTING;
                        end
                    end
                end else if (w_ack) begin
                    w_state_nx = IDLE;
                    w_en_nx    = 1'b0;
                    w_count_nx = '0;
                    w_int_nx   = 1'b0;
                end
            end
            default: w_state_nx = IDLE;
        endcase

        // Config writes override whatever the FSM decided above.
        if (cfg_we) begin
            case (cfg_addr)
                2'd0: begin
                    w_mode_nx = cfg_wdata[1];
                    if (!cfg_wdata[0]) begin
                        w_en_nx    = 1'b0;
                        w_state_nx = IDLE;
                        w_int_nx   = 1'b0;
                        w_count_nx = '0;
                    end else if (r_state == IDLE) begin
                        w_en_nx    = 1'b1;
                        w_state_nx = COUNTING;
                        w_count_nx = w_p;
                        w_int_nx   = 1'b0;
                    end
                end
                2'd1: w_period_nx = CNT_W'(cfg_wdata);
                2'd3: if (cfg_wdata[0]) w_miss_nx = 8'd0;
                default: ;
            endcase
        end
    end

    always_comb begin
        cfg_rdata = 32'd0;
        case (cfg_addr)
            2'd0: cfg_rdata = {30'd0, r_mode, r_en};
            2'd1: cfg_rdata = 32'(r_period);
            2'd2: cfg_rdata = 32'(r_count);
            2'd3: cfg_rdata = {16'd0, r_miss, 6'd0, r_state};
            default: cfg_rdata = 32'd0;
        endcase
    end

    assign interrupt = r_int;

endmodule

// File: tb/tb_int_gen.sv
// Scoreboarded bench for int_gen: per-cycle interrupt expectations are queued as
// stimulus is applied and checked by a monitor on the falling edge.
module tb_int_gen;

    logic        clk;
    logic        reset;
    logic [31:0] m_int_addr;
    logic [3:0]  m_int_byteen;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        interrupt;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string tag;
        logic  exp;
    } exp_t;
    exp_t exp_q[$];

    int_gen dut (
        .clk          (clk),
        .reset        (reset),
        .m_int_addr   (m_int_addr),
        .m_int_byteen (m_int_byteen),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_rdata    (cfg_rdata),
        .interrupt    (interrupt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t it;
            it = exp_q.pop_front();
            chk(it.tag, {31'd0, interrupt}, {31'd0, it.exp});
        end
    end

    // One clock with the given inputs; interrupt expected after that edge.
    task automatic cyc(input string tag, input logic we, input logic [1:0] a,
                       input logic [31:0] wd, input logic [31:0] ia,
                       input logic [3:0] be, input logic e);
        exp_t it;
        cfg_we       = we;
        cfg_addr     = a;
        cfg_wdata    = wd;
        m_int_addr   = ia;
        m_int_byteen = be;
        @(posedge clk);
        #1;
        it.tag = tag;
        it.exp = e;
        exp_q.push_back(it);
        cfg_we       = 1'b0;
        m_int_byteen = 4'd0;
    endtask

    task automatic wr(input string tag, input logic [1:0] a, input logic [31:0] wd, input logic e);
        cyc(tag, 1'b1, a, wd, 32'd0, 4'd0, e);
    endtask

    task automatic idle(input string tag, input int n, input logic e);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0, e);
    endtask

    task automatic st(input string tag, input logic [31:0] ia, input logic [3:0] be, input logic e);
        cyc(tag, 1'b0, 2'd0, 32'd0, ia, be, e);
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        cfg_addr = a;
        #1;
        chk(tag, cfg_rdata, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; reset = 1'b0;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
        m_int_addr = 32'd0; m_int_byteen = 4'd0;
        #1;
        chk("rst_int", {31'd0, interrupt}, 32'd0);
        for (int a = 0; a < 4; a++) rd("rst_reg", 2'(a), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // One-shot, PERIOD=5
        wr("os_per", 2'd1, 32'd5, 1'b0);
        wr("os_en", 2'd0, 32'd1, 1'b0);
        rd("os_cnt0", 2'd2, 32'd5);
        idle("os_wait", 4, 1'b0);
        idle("os_rise", 1, 1'b1);
        rd("os_stat", 2'd3, 32'h0000_0002);
        rd("os_cnthold", 2'd2, 32'd5);
        idle("os_hold", 2, 1'b1);
        st("os_ack", 32'h0000_7F20, 4'hF, 1'b0);
        rd("os_stat_idle", 2'd3, 32'd0);
        rd("os_ctrl", 2'd0, 32'd0);
        rd("os_cnt_clr", 2'd2, 32'd0);

        // Ack filtering
        wr("af_en", 2'd0, 32'd1, 1'b0);
        st("af_ack_cnt", 32'h0000_7F20, 4'hF, 1'b0);
        idle("af_wait", 3, 1'b0);
        idle("af_rise", 1, 1'b1);
        st("af_badaddr", 32'h0000_7F24, 4'hF, 1'b1);
        st("af_nobe", 32'h0000_7F20, 4'h0, 1'b1);
        wr("af_dis", 2'd0, 32'd0, 1'b0);
        rd("af_stat", 2'd3, 32'd0);
        rd("af_cnt", 2'd2, 32'd0);

        // Periodic with misses
        wr("pm_per", 2'd1, 32'd3, 1'b0);
        wr("pm_en", 2'd0, 32'd3, 1'b0);
        idle("pm_wait", 2, 1'b0);
        idle("pm_rise", 1, 1'b1);
        idle("pm_miss", 10, 1'b1);
        rd("pm_stat", 2'd3, 32'h0000_0302);
        rd("pm_cnt", 2'd2, 32'd2);
        st("pm_ack", 32'h0000_7F20, 4'hF, 1'b0);
        rd("pm_cnt_ack", 2'd2, 32'd1);
        idle("pm_rerise", 1, 1'b1);
        wr("pm_clr", 2'd3, 32'd1, 1'b1);
        rd("pm_stat_clr", 2'd3, 32'h0000_0002);
        wr("pm_dis", 2'd0, 32'd0, 1'b0);
        rd("pm_stat_dis", 2'd3, 32'd0);

        // Ack on the same edge as a periodic expiry
        wr("sx_per", 2'd1, 32'd2, 1'b0);
        wr("sx_en", 2'd0, 32'd3, 1'b0);
        idle("sx_wait", 1, 1'b0);
        idle("sx_rise", 2, 1'b1);
        st("sx_ack", 32'h0000_7F20, 4'h1, 1'b1);
        rd("sx_cnt", 2'd2, 32'd2);
        rd("sx_stat", 2'd3, 32'h0000_0002);
        wr("sx_dis", 2'd0, 32'd0, 1'b0);

        // PERIOD=0 behaves as 1
        wr("p0_per", 2'd1, 32'd0, 1'b0);
        wr("p0_en", 2'd0, 32'd1, 1'b0);
        rd("p0_cnt", 2'd2, 32'd1);
        idle("p0_rise", 1, 1'b1);
        wr("p0_dis", 2'd0, 32'd0, 1'b0);

        // Miss counter saturation, PERIOD=1 periodic
        wr("sat_per", 2'd1, 32'd1, 1'b0);
        wr("sat_en", 2'd0, 32'd3, 1'b0);
        idle("sat_rise", 1, 1'b1);
        idle("sat_run", 254, 1'b1);
        rd("sat_254", 2'd3, 32'h0000_FE02);
        idle("sat_run2", 46, 1'b1);
        rd("sat_255", 2'd3, 32'h0000_FF02);
        wr("sat_clr", 2'd3, 32'd1, 1'b1);
        rd("sat_clr_prio", 2'd3, 32'h0000_0002);

        // Reset mid-assert drops interrupt without a clock edge
        @(negedge clk);
        #1;
        chk("mr_pre", {31'd0, interrupt}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mr_int", {31'd0, interrupt}, 32'd0);
        for (int a = 0; a < 4; a++) rd("mr_reg", 2'(a), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
